// File: rtl/prog_loader_pkg.sv
// ============================================================
// prog_loader_pkg : shared types and constants for prog_loader
// Rev 1.0
// ============================================================
`default_nettype none

package prog_loader_pkg;

   localparam int MEM_BYTES = 64;
   localparam int BYTE_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_LEN = 3'd1,
      ST_GET_PAY = 3'd2,
      ST_GET_CHK = 3'd3,
      ST_STREAM  = 3'd4,
      ST_RUN     = 3'd5,
      ST_ERROR   = 3'd6
   } state_t;

   // A frame is legal when it is non-empty and ends inside processor memory.
   function automatic logic frame_fits(input logic [BYTE_W-1:0] addr,
                                       input logic [BYTE_W-1:0] len);
      logic [BYTE_W:0] end_addr;
      end_addr = {1'b0, addr} + {1'b0, len};
      return (len != '0) && (end_addr <= (BYTE_W+1)'(MEM_BYTES));
   endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_if.sv
// ============================================================
// prog_loader_if : host byte-stream valid/ready handshake
// Rev 1.0
// ============================================================
`default_nettype none

interface prog_loader_if;
   import prog_loader_pkg::*;

   logic              s_valid;
   logic [BYTE_W-1:0] s_data;
   logic              s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

`default_nettype wire

// File: rtl/prog_fifo.sv
// ============================================================
// prog_fifo : single-clock show-ahead FIFO for frame payload
// Rev 1.0
// ============================================================
`default_nettype none

module prog_fifo #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   // Extra MSB distinguishes full from empty when the indices coincide.
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;
   assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================
// prog_loader : buffers an ADDR/LEN/payload frame, streams it to the core
// Optional trailing CHK byte: define PROG_LOADER_CHECKSUM_EN.  Rev 1.0
// ============================================================
`default_nettype none

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int BUF_DEPTH = MEM_BYTES
) (
   input  logic              clk,
   input  logic              rst,
   prog_loader_if.slave      host,
   output logic [BYTE_W-1:0] ld_data,
   output logic              ld_start,
   output logic              proc_rst_n,
   output logic              busy,
   output logic              err
);

   state_t            r_state, w_state_nx;
   logic              r_armed;
   logic [BYTE_W-1:0] r_addr, w_addr_nx;
   logic [BYTE_W-1:0] r_len, w_len_nx;
   logic [BYTE_W-1:0] r_cnt, w_cnt_nx;
   logic              w_ready;
   logic              w_push, w_pop, w_flush;
   logic              w_full, w_empty;
   logic [BYTE_W-1:0] w_rd_data;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [BYTE_W-1:0] r_sum, w_sum_nx;
`endif

   assign host.s_ready = w_ready;

   prog_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (w_flush),
      .push    (w_push),
      .wr_data (host.s_data),
      .pop     (w_pop),
      .rd_data (w_rd_data),
      .full    (w_full),
      .empty   (w_empty)
   );

   // r_armed keeps s_ready low for the first cycle out of reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_armed <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_armed <= 1'b1;
         r_addr  <= w_addr_nx;
         r_len   <= w_len_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (!rst) r_sum <= '0;
      else      r_sum <= w_sum_nx;
   end
`endif

   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_len_nx   = r_len;
      w_cnt_nx   = r_cnt;
`ifdef PROG_LOADER_CHECKSUM_EN
      w_sum_nx   = r_sum;
`endif
      w_ready    = 1'b0;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_flush    = 1'b0;
      ld_data    = '0;
      ld_start   = 1'b0;
      proc_rst_n = 1'b0;
      busy       = 1'b0;
      err        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_ready = r_armed;
            if (r_armed && host.s_valid) begin
               w_addr_nx  = host.s_data;
               w_cnt_nx   = '0;
               w_state_nx = ST_GET_LEN;
`ifdef PROG_LOADER_CHECKSUM_EN
               w_sum_nx   = host.s_data;
`endif
            end
         end

         ST_GET_LEN: begin
            busy    = 1'b1;
            w_ready = 1'b1;
            if (host.s_valid) begin
               if (!frame_fits(r_addr, host.s_data)) begin
                  w_state_nx = ST_ERROR;
               end else begin
                  w_len_nx   = host.s_data;
                  w_state_nx = ST_GET_PAY;
`ifdef PROG_LOADER_CHECKSUM_EN
                  w_sum_nx   = r_sum + host.s_data;
`endif
               end
            end
         end

         ST_GET_PAY: begin
            busy    = 1'b1;
            w_ready = !w_full;
            if (host.s_valid && !w_full) begin
               w_push   = 1'b1;
               w_cnt_nx = r_cnt + 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
               w_sum_nx = r_sum + host.s_data;
`endif
               if ((r_cnt + 8'd1) == r_len) begin
                  w_cnt_nx   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  w_state_nx = ST_GET_CHK;
`else
                  w_state_nx = ST_STREAM;
`endif
               end
            end
         end

`ifdef PROG_LOADER_CHECKSUM_EN
         ST_GET_CHK: begin
            busy    = 1'b1;
            w_ready = 1'b1;
            if (host.s_valid) begin
               w_state_nx = (host.s_data == r_sum) ? ST_STREAM : ST_ERROR;
            end
         end
`endif

         // Count 0 presents ADDR, counts 1..LEN pop payload in order.
         ST_STREAM: begin
            busy       = 1'b1;
            proc_rst_n = 1'b1;
            if (r_cnt == '0) begin
               ld_data = r_addr;
            end else begin
               ld_data = w_empty ? '0 : w_rd_data;
               w_pop   = 1'b1;
            end
            if (r_cnt == r_len) w_state_nx = ST_RUN;
            else                w_cnt_nx   = r_cnt + 8'd1;
         end

         ST_RUN: begin
            ld_start   = 1'b1;
            proc_rst_n = 1'b1;
         end

         ST_ERROR: begin
            err     = 1'b1;
            w_flush = 1'b1;
         end

         default: w_state_nx = ST_IDLE;
      endcase
   end

endmodule

`default_nettype wire
